i2c_write_master: RTL and testbench
===================================

I2C_WRITE_MASTER -- requirements
Module: i2c_write_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning clk cycles per SCL quarter-period (50 MHz -> 100 kHz).
REQ-002 SHALL have port clk  in  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_addr_w_rw  in  8  slave address [7:1] plus R/W bit [0]; bit 0 is forced to 0 on the wire.
REQ-005 SHALL have port i_sub_addr  in  8  slave register sub-address.
REQ-006 SHALL have port i_data_write  in  8  data byte to write.
REQ-007 SHALL have port req_trans  in  1  transaction request; a rising edge starts one transaction.
REQ-008 SHALL have port sda_i  in  1  sampled SDA line.
REQ-009 SHALL have port scl_i  in  1  sampled SCL line (used only under I2C_CLK_STRETCH_EN).
REQ-010 SHALL have port i2c_busy  out  1  high while a transaction is in progress.
REQ-011 SHALL have port scl_oe  out  1  1 = pull SCL low, 0 = release (open drain).
REQ-012 SHALL have port sda_oe  out  1  1 = pull SDA low, 0 = release.
REQ-013 SHALL have port nack_err  out  1  sticky NACK flag for the last transaction.

Function
REQ-014 SHALL register req_trans and detect 0->1 only; a level held high SHALL NOT retrigger.
REQ-015 SHALL, on a detected edge in IDLE, latch all three bytes and set i2c_busy on the next clk edge (1-cycle latency).
REQ-016 SHALL ignore request edges while i2c_busy=1.
REQ-017 SHALL run the FSM IDLE -> START -> ADDR -> ACK1 -> SUB -> ACK2 -> DATA -> ACK3 -> STOP -> IDLE.
REQ-018 SHALL split each bit into 4 phases of CLK_DIV cycles: SCL low / SDA change, SCL low hold, SCL high, SCL high / sample.
REQ-019 SHALL generate START as SDA falling while SCL is released, and STOP as SDA rising while SCL is released.
REQ-020 SHALL shift bytes MSB first using a 3-bit bit counter that wraps 7->0 at each byte boundary.
REQ-021 SHALL release SDA during each ACK bit and sample sda_i in phase 3; a value of 1 is a NACK.
REQ-022 SHALL, on NACK, set nack_err, skip the remaining bytes and go directly to STOP.
REQ-023 SHALL clear nack_err when the next transaction is accepted.
REQ-024 SHALL deassert i2c_busy in the cycle after the STOP phase 3 ends; IDLE releases both lines.
REQ-025 SHALL have a total transaction time of (1 + 27 + 1) bit times x 4 x CLK_DIV cycles, ±1 cycle.

Reset
REQ-026 SHALL, while reset_n=0, set i2c_busy=0, scl_oe=0, sda_oe=0, nack_err=0, the FSM to IDLE, and all counters to 0.
REQ-027 SHALL, on reset asserted mid-transaction, release both lines immediately with no STOP generated.
REQ-028 SHALL, after reset, not treat a req_trans already high as an edge (edge register resets to 1).

Configuration
REQ-029 SHALL, with I2C_CLK_STRETCH_EN defined, hold the phase-2 counter while scl_i=0 with SCL released, so slave clock stretching extends the bit.
REQ-030 SHALL, without I2C_CLK_STRETCH_EN, ignore scl_i and run open-loop timing.

Structure
REQ-031 SHALL place the FSM state enum, phase constants and byte count (3) in shared package i2c_pkg.
REQ-032 SHALL use sub-module i2c_phase_gen, a CLK_DIV divider emitting a 1-cycle phase tick and a 2-bit phase index.

Verification
REQ-033 SHALL test: addr 0xB8, sub 0x03, data 0x6F, slave ACKs all -> wire bytes B8,03,6F, 3 ACKs, STOP, nack_err=0, busy high for the expected cycle count.
REQ-034 SHALL test: slave NACKs the address byte -> nack_err=1, STOP immediately after ACK1, no SUB/DATA bits driven.
REQ-035 SHALL test: req_trans held high across two transactions -> exactly one transaction; a second rising edge while busy is ignored.
REQ-036 SHALL test: reset_n pulsed low during the SUB byte -> scl_oe=sda_oe=0 the same cycle, busy=0, next request completes normally.
REQ-037 SHALL test: with I2C_CLK_STRETCH_EN, scl_i held low 500 cycles in DATA bit 4 -> bit extended by 500 cycles, data unchanged.
REQ-038 SHALL test: i_addr_w_rw=0xB9 -> wire address byte 0xB8 (write forced).

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg : FSM states, bit-phase indices and byte count for the I2C write master
// Rev 1.0
// ============================================================================
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_ADDR  = 4'd2,
    ST_ACK1  = 4'd3,
    ST_SUB   = 4'd4,
    ST_ACK2  = 4'd5,
    ST_DATA  = 4'd6,
    ST_ACK3  = 4'd7,
    ST_STOP  = 4'd8
  } state_t;

  // Each bit is four equal phases; SCL is low in 0/1 and released in 2/3.
  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam int         NUM_BYTES      = 3;
  localparam logic [2:0] LAST_BIT       = 3'd7;
  localparam int         BITS_PER_TRANS = 2 + NUM_BYTES * 9;

endpackage
`default_nettype wire

// File: rtl/i2c_phase_gen.sv
`default_nettype none
// ============================================================================
// i2c_phase_gen : divides clk by CLK_DIV into a phase tick and a 2-bit phase index
// Rev 1.0
// ============================================================================
module i2c_phase_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  // tick marks the final cycle of the current phase; phase is valid alongside it
  assign tick = run && !hold && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (!hold) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_write_master.sv
`default_nettype none
// ============================================================================
// i2c_write_master : 3-byte I2C write (addr, sub-addr, data); optional I2C_CLK_STRETCH_EN
// Rev 1.0
// ============================================================================
module i2c_write_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_addr_w_rw,
  input  logic [7:0] i_sub_addr,
  input  logic [7:0] i_data_write,
  input  logic       req_trans,
  input  logic       sda_i,
  input  logic       scl_i,
  output logic       i2c_busy,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       nack_err
);
  import i2c_pkg::*;

  state_t     state, state_nx;
  logic       req_q, req_rise, tick, bit_end, stretch_hold;
  logic [1:0] phase;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q, sub_q, data_q;
  logic       unused_rw;

  // The R/W bit is always sent as write
  assign unused_rw = i_addr_w_rw[0];

  assign req_rise = req_trans & ~req_q;
  assign bit_end  = tick & (phase == PH_3);
  assign i2c_busy = (state != ST_IDLE);

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low after we release it freezes the bit timing
  assign stretch_hold = (phase == PH_2) && !scl_oe && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stretch_hold = 1'b0;
`endif

  i2c_phase_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (i2c_busy),
    .hold   (stretch_hold),
    .tick   (tick),
    .phase  (phase)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    scl_oe   = 1'b0;
    sda_oe   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_rise) state_nx = ST_START;
      end
      ST_START: begin
        sda_oe = phase[1];
        if (bit_end) state_nx = ST_ADDR;
      end
      ST_ADDR, ST_SUB, ST_DATA: begin
        scl_oe = ~phase[1];
        sda_oe = ~shift_q[7];
        if (bit_end && (bit_cnt == LAST_BIT)) begin
          state_nx = (state == ST_ADDR) ? ST_ACK1 :
                     (state == ST_SUB)  ? ST_ACK2 : ST_ACK3;
        end
      end
      ST_ACK1, ST_ACK2, ST_ACK3: begin
        scl_oe = ~phase[1];
        if (bit_end) begin
          if (sda_i || (state == ST_ACK3)) state_nx = ST_STOP;
          else state_nx = (state == ST_ACK1) ? ST_SUB : ST_DATA;
        end
      end
      ST_STOP: begin
        scl_oe = ~phase[1];
        sda_oe = (phase != PH_3);
        if (bit_end) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Edge register resets high so a request held through reset is not an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q    <= 1'b1;
      shift_q  <= 8'h00;
      sub_q    <= 8'h00;
      data_q   <= 8'h00;
      bit_cnt  <= 3'd0;
      nack_err <= 1'b0;
    end else begin
      req_q <= req_trans;
      if ((state == ST_IDLE) && req_rise) begin
        shift_q  <= {i_addr_w_rw[7:1], 1'b0};
        sub_q    <= i_sub_addr;
        data_q   <= i_data_write;
        bit_cnt  <= 3'd0;
        nack_err <= 1'b0;
      end else if (bit_end) begin
        case (state)
          ST_ADDR, ST_SUB, ST_DATA: begin
            shift_q <= {shift_q[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_ACK1, ST_ACK2, ST_ACK3: begin
            if (sda_i) nack_err <= 1'b1;
            shift_q <= (state == ST_ACK1) ? sub_q : data_q;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_write_master.sv
`default_nettype none
// ============================================================================
// tb_i2c_write_master : randomized bench with a bus-level I2C slave model
// Rev 1.0
// ============================================================================
module tb_i2c_write_master;

  localparam int CLK_DIV = 4;
  localparam int BIT_CYC = 4 * CLK_DIV;
  localparam int LIMIT   = 40 * BIT_CYC + 2000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] addr, sub, data;
  logic       req_trans;
  logic       sda_i, scl_i;
  logic       i2c_busy, scl_oe, sda_oe, nack_err;

  logic       slave_pull  = 1'b0;
  logic       stretch_low = 1'b0;
  int         errors = 0;
  int         checks = 0;

  // Slave/bus model state
  logic [7:0] byte_q[$];
  logic       ack_q[$];
  int         starts = 0, stops = 0, scl_rises = 0;
  int         bit_cnt = 0, frame_byte = 0, nack_at = -1;
  logic       in_frame = 1'b0;
  logic [7:0] cur = 8'h00;

  always #5 clk = ~clk;

  assign scl_i = !scl_oe && !stretch_low;
  assign sda_i = !sda_oe && !slave_pull;

  i2c_write_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_addr_w_rw (addr),
    .i_sub_addr  (sub),
    .i_data_write(data),
    .req_trans   (req_trans),
    .sda_i       (sda_i),
    .scl_i       (scl_i),
    .i2c_busy    (i2c_busy),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .nack_err    (nack_err)
  );

  // Open-drain bus watcher: decodes START/STOP, bits on SCL rise, ACKs the chosen bytes
  initial begin : bus_monitor
    logic prev_scl, prev_sda, s_scl, s_sda;
    prev_scl = 1'b1;
    prev_sda = 1'b1;
    forever begin
      @(negedge clk);
      s_scl = scl_i;
      s_sda = sda_i;
      if (!reset_n) begin
        in_frame   = 1'b0;
        bit_cnt    = 0;
        slave_pull = 1'b0;
      end else if (s_scl && prev_scl && prev_sda && !s_sda) begin
        starts++;
        in_frame   = 1'b1;
        bit_cnt    = 0;
        frame_byte = 0;
      end else if (s_scl && prev_scl && !prev_sda && s_sda) begin
        stops++;
        in_frame   = 1'b0;
        slave_pull = 1'b0;
      end else if (in_frame && s_scl && !prev_scl) begin
        scl_rises++;
        if (bit_cnt < 8) begin
          cur = {cur[6:0], s_sda};
          bit_cnt++;
          if (bit_cnt == 8) byte_q.push_back(cur);
        end else begin
          ack_q.push_back(s_sda);
          bit_cnt = 0;
          frame_byte++;
        end
      end else if (in_frame && !s_scl && prev_scl) begin
        slave_pull = (bit_cnt == 8) && (frame_byte != nack_at);
      end
      prev_scl = s_scl;
      prev_sda = s_sda;
    end
  end

  task automatic do_trans(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                          input int nack_byte, input bit keep_high,
                          output int busy_cycles, output logic busy_before,
                          output logic busy_after, output logic err_at_start);
    nack_at = nack_byte;
    @(negedge clk);
    addr = a; sub = s; data = d;
    req_trans = 1'b1;
    #1 busy_before = i2c_busy;
    @(negedge clk);
    busy_after   = i2c_busy;
    err_at_start = nack_err;
    busy_cycles  = 0;
    while (i2c_busy && busy_cycles < LIMIT) begin
      busy_cycles++;
      @(negedge clk);
    end
    if (!keep_high) req_trans = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    repeat (3) @(negedge clk);
    checks++;
    if ({i2c_busy, scl_oe, sda_oe, nack_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: busy/scl_oe/sda_oe/nack=%b required 0000",
               {i2c_busy, scl_oe, sda_oe, nack_err});
    end
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (i2c_busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL held_req_after_reset: busy cycles=%0d required 0", seen);
    end
    req_trans = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_transaction(input string tag, input logic [7:0] a, input logic [7:0] s,
                                  input logic [7:0] d, input int nack_byte);
    int         b0, k0, r0, st0, sp0, nb, cyc, exp_cyc;
    logic       bb, ba, es;
    logic [7:0] exp_b[3];
    exp_b[0] = {a[7:1], 1'b0};
    exp_b[1] = s;
    exp_b[2] = d;
    nb      = (nack_byte < 0) ? 3 : nack_byte + 1;
    exp_cyc = (2 + 9 * nb) * BIT_CYC;
    b0 = byte_q.size(); k0 = ack_q.size(); r0 = scl_rises; st0 = starts; sp0 = stops;
    do_trans(a, s, d, nack_byte, 1'b0, cyc, bb, ba, es);
    checks++;
    if (bb !== 1'b0 || ba !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: busy before/after edge=%b/%b required 0/1", tag, bb, ba);
    end
    checks++;
    if (es !== 1'b0) begin
      errors++;
      $display("FAIL %s nack_clear: nack_err at accept=%b required 0", tag, es);
    end
    checks++;
    if (cyc < exp_cyc - 1 || cyc > exp_cyc + 1) begin
      errors++;
      $display("FAIL %s busy_len: cycles=%0d required %0d", tag, cyc, exp_cyc);
    end
    checks++;
    if (byte_q.size() - b0 != nb || ack_q.size() - k0 != nb) begin
      errors++;
      $display("FAIL %s byte_count: bytes=%0d acks=%0d required %0d", tag,
               byte_q.size() - b0, ack_q.size() - k0, nb);
    end else begin
      for (int i = 0; i < nb; i++) begin
        checks++;
        if (byte_q[b0 + i] !== exp_b[i] || ack_q[k0 + i] !== (i == nack_byte)) begin
          errors++;
          $display("FAIL %s byte%0d: wire=%h ack_bit=%b required %h/%b", tag, i,
                   byte_q[b0 + i], ack_q[k0 + i], exp_b[i], (i == nack_byte));
        end
      end
    end
    checks++;
    if (nack_err !== (nack_byte >= 0)) begin
      errors++;
      $display("FAIL %s nack_err: %b required %b", tag, nack_err, (nack_byte >= 0));
    end
    checks++;
    if (scl_rises - r0 != 9 * nb + 1 || starts - st0 != 1 || stops - sp0 != 1) begin
      errors++;
      $display("FAIL %s framing: scl_rises=%0d starts=%0d stops=%0d required %0d/1/1", tag,
               scl_rises - r0, starts - st0, stops - sp0, 9 * nb + 1);
    end
    checks++;
    if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_lines: scl_oe=%b sda_oe=%b required 0/0", tag, scl_oe, sda_oe);
    end
  endtask

  task automatic test_held_high();
    int   st0, cyc, extra;
    logic bb, ba, es;
    st0 = starts;
    fork
      do_trans(8'h42, 8'h10, 8'h99, -1, 1'b1, cyc, bb, ba, es);
      begin
        repeat (3 * BIT_CYC) @(negedge clk);
        req_trans = 1'b0;
        repeat (4) @(negedge clk);
        req_trans = 1'b1;
      end
    join
    extra = 0;
    repeat (10 * BIT_CYC) begin
      @(negedge clk);
      if (i2c_busy) extra++;
    end
    checks++;
    if (extra != 0 || starts - st0 != 1 || cyc < 29 * BIT_CYC - 1 || cyc > 29 * BIT_CYC + 1) begin
      errors++;
      $display("FAIL held_high: retrigger_cycles=%0d starts=%0d len=%0d required 0/1/%0d",
               extra, starts - st0, cyc, 29 * BIT_CYC);
    end
    req_trans = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int   k0, cyc, waited;
    logic bb, ba, es, busy_pre;
    k0 = ack_q.size();
    waited = 0;
    busy_pre = 1'b0;
    fork
      do_trans(8'hA6, 8'h5A, 8'h3C, -1, 1'b0, cyc, bb, ba, es);
      begin
        while (!(ack_q.size() > k0 && bit_cnt >= 3) && waited < LIMIT) begin
          @(posedge clk);
          waited++;
        end
        #2 busy_pre = i2c_busy;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy_pre !== 1'b1 || waited >= LIMIT) begin
          errors++;
          $display("FAIL reset_mid_reach: busy=%b waited=%0d required busy=1 in SUB", busy_pre, waited);
        end
        checks++;
        if ({scl_oe, sda_oe, i2c_busy, nack_err} !== 4'b0000) begin
          errors++;
          $display("FAIL reset_mid_release: scl_oe/sda_oe/busy/nack=%b required 0000",
                   {scl_oe, sda_oe, i2c_busy, nack_err});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    checks++;
    if (cyc >= 29 * BIT_CYC - 1) begin
      errors++;
      $display("FAIL reset_mid_abort: busy cycles=%0d required < %0d", cyc, 29 * BIT_CYC - 1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] a, s, d;
    int         r;
    for (int n = 0; n < 8; n++) begin
      a = 8'($urandom);
      s = 8'($urandom);
      d = 8'($urandom);
      r = $urandom_range(0, 5);
      test_transaction($sformatf("rand%0d", n), a, s, d, (r > 2) ? -1 : r);
    end
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic test_stretch();
    int   b0, k0, cyc, waited;
    logic bb, ba, es;
    b0 = byte_q.size();
    k0 = ack_q.size();
    waited = 0;
    fork
      do_trans(8'hB8, 8'h03, 8'h6F, -1, 1'b0, cyc, bb, ba, es);
      begin
        while (!(ack_q.size() - k0 == 2 && bit_cnt == 3 && scl_oe) && waited < LIMIT) begin
          @(posedge clk); #1;
          waited++;
        end
        while (scl_oe && waited < LIMIT) begin
          @(posedge clk); #1;
          waited++;
        end
        stretch_low = 1'b1;
        repeat (500) @(posedge clk);
        #1 stretch_low = 1'b0;
      end
    join
    checks++;
    if (waited >= LIMIT || cyc < 29 * BIT_CYC + 499 || cyc > 29 * BIT_CYC + 501) begin
      errors++;
      $display("FAIL stretch_len: cycles=%0d required %0d", cyc, 29 * BIT_CYC + 500);
    end
    checks++;
    if (byte_q.size() - b0 != 3 || byte_q[byte_q.size() - 1] !== 8'h6F || nack_err !== 1'b0) begin
      errors++;
      $display("FAIL stretch_data: bytes=%0d last=%h nack=%b required 3/6f/0",
               byte_q.size() - b0, byte_q[byte_q.size() - 1], nack_err);
    end
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    req_trans = 1'b1;
    addr = 8'h00; sub = 8'h00; data = 8'h00;
    test_reset();
    test_transaction("ack_all", 8'hB8, 8'h03, 8'h6F, -1);
    test_transaction("force_write", 8'hB9, 8'h03, 8'h6F, -1);
    test_transaction("nack_addr", 8'hB8, 8'h03, 8'h6F, 0);
    test_transaction("nack_data", 8'h5C, 8'hE1, 8'h0F, 2);
    test_held_high();
    test_reset_mid();
    test_transaction("after_reset", 8'hA6, 8'h5A, 8'h3C, -1);
    test_random();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
